// File: rtl/cnt_arb.sv
// Two-requester round-robin arbiter that loads a divided-clock counter, waits
// for its carry (or a timeout) and returns a one-cycle done pulse to the winner.
module cnt_arb #(
    parameter int unsigned LD_HOLD = 8,
    parameter int unsigned TMO     = 255
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] di0,
    input  logic [3:0] di1,
    input  logic [1:0] set0,
    input  logic [1:0] set1,
    input  logic       cy_in,
    output logic       ld,
    output logic [3:0] di,
    output logic [1:0] clk_set,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       err,
    output logic       busy
);

    localparam int unsigned LDW = (LD_HOLD > 1) ? $clog2(LD_HOLD) : 1;
    localparam int unsigned TW  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [LDW-1:0]  ld_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            last_gnt;
    logic            sync0, sync1, sync2;
    logic [1:0]      win_c;
    logic            carry_c;

    // Round-robin pick: the requester not granted last time wins a tie.
    always_comb begin
        win_c = 2'b00;
        case (req)
            2'b01:   win_c = 2'b01;
            2'b10:   win_c = 2'b10;
            2'b11:   win_c = last_gnt ? 2'b01 : 2'b10;
            default: win_c = 2'b00;
        endcase
    end

    // Carry event: rising edge of the synchronized counter carry.
    assign carry_c = sync1 & ~sync2;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ld       <= 1'b0;
            di       <= 4'd0;
            clk_set  <= 2'd0;
            gnt      <= 2'd0;
            done     <= 2'd0;
            err      <= 1'b0;
            busy     <= 1'b0;
            ld_cnt   <= '0;
            tmo_cnt  <= '0;
            last_gnt <= 1'b1;
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
        end else begin
            sync0 <= cy_in;
            sync1 <= sync0;
            sync2 <= sync1;
            done  <= 2'd0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_c != 2'b00) begin
                        gnt      <= win_c;
                        last_gnt <= win_c[1];
                        di       <= win_c[1] ? di1 : di0;
                        clk_set  <= win_c[1] ? set1 : set0;
                        ld       <= 1'b1;
                        ld_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (ld_cnt == LDW'(LD_HOLD - 1)) begin
                        ld      <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= RUN;
                    end else begin
                        ld_cnt <= ld_cnt + LDW'(1);
                    end
                end
                // Carry takes priority over a timeout landing on the same cycle.
                RUN: begin
                    if (carry_c) begin
                        done  <= gnt;
                        state <= DONE;
                    end else if (tmo_cnt == TW'(TMO)) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                DONE: begin
                    gnt   <= 2'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
